// File: rtl/echo_pipe_serializer.sv
// Transmit side of the echo request pipe: buffers up to two whole {v, meth, tag}
// messages and streams each one out as a header / meth / v triple of narrow beats.
module echo_pipe_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEQ_WIDTH  = 8,
    parameter int unsigned MAX_TAG    = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    pipe_enq__ENA,
    input  logic [3*DATA_WIDTH-1:0] pipe_enq_v,
    output logic                    pipe_enq__RDY,
    output logic                    beat_enq__ENA,
    output logic [DATA_WIDTH-1:0]   beat_enq_v,
    output logic                    beat_enq_last,
    input  logic                    beat_enq__RDY,
    output logic [15:0]             err_count
);

    typedef enum logic [1:0] {IDLE, HDR, METH, VAL} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] v;
        logic [DATA_WIDTH-1:0] meth;
        logic [7:0]            tag;
        logic [SEQ_WIDTH-1:0]  seq;
    } slot_t;

    state_t                state;
    slot_t                 cur, nxt, incoming;
    logic                  cur_valid, nxt_valid;
    logic [SEQ_WIDTH-1:0]  seq;
    logic [DATA_WIDTH-1:0] in_tag, in_meth, in_v;
    logic                  tag_ok, accept, reject, fire, finishing;

    assign in_tag  = pipe_enq_v[DATA_WIDTH-1:0];
    assign in_meth = pipe_enq_v[2*DATA_WIDTH-1:DATA_WIDTH];
    assign in_v    = pipe_enq_v[3*DATA_WIDTH-1:2*DATA_WIDTH];

    assign pipe_enq__RDY = !nxt_valid;
    assign tag_ok        = (in_tag != '0) && (in_tag <= DATA_WIDTH'(MAX_TAG));
    assign accept        = pipe_enq__ENA && pipe_enq__RDY && tag_ok;
    assign reject        = pipe_enq__ENA && pipe_enq__RDY && !tag_ok;

    assign beat_enq__ENA = (state != IDLE) && beat_enq__RDY;
    assign fire          = beat_enq__ENA;
    assign finishing     = fire && (state == VAL);
    assign beat_enq_last = (state == VAL);

    always_comb begin
        incoming      = '0;
        incoming.v    = in_v;
        incoming.meth = in_meth;
        incoming.tag  = in_tag[7:0];
        incoming.seq  = seq;
    end

    // Payload is a mux of registered slot/state only; nothing from pipe_enq_v reaches it.
    always_comb begin
        beat_enq_v = '0;
        unique case (state)
            HDR:     beat_enq_v = DATA_WIDTH'({8'hEC, 8'(cur.seq), 8'd2, cur.tag});
            METH:    beat_enq_v = cur.meth;
            VAL:     beat_enq_v = cur.v;
            default: beat_enq_v = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cur       <= '0;
            nxt       <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            seq       <= '0;
            err_count <= '0;
        end else begin
            if (reject && err_count != '1)
                err_count <= err_count + 16'd1;
            if (accept)
                seq <= seq + SEQ_WIDTH'(1);

            // A finishing VAL beat frees cur, so a same-cycle accept (only possible
            // with nxt empty) lands directly in cur.
            if (finishing) begin
                if (nxt_valid) begin
                    cur       <= nxt;
                    nxt_valid <= 1'b0;
                end else if (accept) begin
                    cur <= incoming;
                end else begin
                    cur_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!cur_valid) begin
                    cur       <= incoming;
                    cur_valid <= 1'b1;
                end else begin
                    nxt       <= incoming;
                    nxt_valid <= 1'b1;
                end
            end

            unique case (state)
                IDLE: if (cur_valid || accept) state <= HDR;
                HDR:  if (fire) state <= METH;
                METH: if (fire) state <= VAL;
                VAL:  if (fire) state <= (nxt_valid || accept) ? HDR : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    no_enq_when_full: assert property (@(posedge CLK) disable iff (!nRST)
        !(pipe_enq__ENA && !pipe_enq__RDY))
        else $error("pipe.enq fired while pipe_enq__RDY was low");

endmodule
